// File: rtl/vga_sync_gen.sv
// Raster timing generator. Produces pixel coordinates for the renderer, plus sync and blanked
// colour outputs aligned to the renderer's latency, and a frame tick and frame counter.
module vga_sync_gen #(
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SW     = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SW     = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned PIPE     = 1,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] rgb_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixel_tick,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb_out,
  output logic       frame_tick,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SW + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SW + V_BP;
  localparam int unsigned HsStart = H_DISP + H_FP;
  localparam int unsigned HsEnd   = H_DISP + H_FP + H_SW;
  localparam int unsigned VsStart = V_DISP + V_FP;
  localparam int unsigned VsEnd   = V_DISP + V_FP + V_SW;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      XLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      YLast   = 10'(V_TOTAL - 1);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [PIPE:0]   hs_q, hs_d, vs_q, vs_d;
  logic [2:0]      rgb_q, rgb_d;
  logic            frame_tick_q, frame_tick_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            hs_raw, vs_raw, von_dly, frame_end;

  assign pixel_tick = (div_cnt_q == DivLast);
  assign video_on   = (32'(x_q) < H_DISP) && (32'(y_q) < V_DISP);
  assign frame_end  = pixel_tick && (x_q == XLast) && (y_q == YLast);

  // Raw sync levels already carry the output polarity.
  assign hs_raw = ((32'(x_q) >= HsStart) && (32'(x_q) < HsEnd)) ? SYNC_POL : ~SYNC_POL;
  assign vs_raw = ((32'(y_q) >= VsStart) && (32'(y_q) < VsEnd)) ? SYNC_POL : ~SYNC_POL;

  always_comb begin
    div_cnt_d    = pixel_tick ? '0 : div_cnt_q + DivW'(1);
    x_d          = x_q;
    y_d          = y_q;
    if (pixel_tick) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    rgb_d        = von_dly ? rgb_in : 3'b000;
    frame_tick_d = frame_end;
    frame_cnt_d  = frame_end ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  // Sync runs PIPE+1 flops; video_on runs PIPE flops plus the rgb_out flop.
  if (PIPE == 0) begin : g_no_pipe
    always_comb begin
      hs_d = hs_raw;
      vs_d = vs_raw;
    end
    assign von_dly = video_on;
  end else begin : g_pipe
    logic [PIPE-1:0] von_q, von_d;

    always_comb begin
      hs_d  = {hs_q[PIPE-1:0], hs_raw};
      vs_d  = {vs_q[PIPE-1:0], vs_raw};
      von_d = PIPE'({von_q, video_on});
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        von_q <= '0;
      end else begin
        von_q <= von_d;
      end
    end

    assign von_dly = von_q[PIPE-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      hs_q         <= {(PIPE + 1){~SYNC_POL}};
      vs_q         <= {(PIPE + 1){~SYNC_POL}};
      rgb_q        <= '0;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      rgb_q        <= rgb_d;
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign hsync      = hs_q[PIPE];
  assign vsync      = vs_q[PIPE];
  assign rgb_out    = rgb_q;
  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
